// File: rtl/serial_pattern_generator.sv
// Serial pattern source: sends a captured word MSB-first with repeats and idle gaps,
// and flags where a golden Mealy overlapping detector would match TARGET on dout.
module serial_pattern_generator #(
  parameter int              WIDTH  = 4,
  parameter int              TLEN   = 4,
  parameter logic [TLEN-1:0] TARGET = 4'b1101
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pat_data,
  input  logic [7:0]       repeat_cnt,
  input  logic [3:0]       gap,
  input  logic             load,
  output logic             ready,
  output logic             dout,
  output logic             dout_valid,
  output logic             match_exp,
  output logic             done
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] IDX_MSB = IW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] word_q;
  logic [7:0]       rep_q;
  logic [3:0]       gap_cfg_q;
  logic [3:0]       gap_cnt_q;
  logic [IW-1:0]    idx_q;
  logic [IW-1:0]    idx_d;
  logic [TLEN-2:0]  hist_q;
  logic [TLEN-2:0]  hist_d;
  logic [TLEN-1:0]  window;
  logic             ready_q;
  logic             dout_q;
  logic             valid_q;
  logic             done_q;

  // idx_q always names the bit currently on dout
  always_comb begin
    idx_d  = idx_q - IW'(1);
    window = {hist_q, dout_q};
    hist_d = window[TLEN-2:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      word_q    <= '0;
      rep_q     <= '0;
      gap_cfg_q <= '0;
      gap_cnt_q <= '0;
      idx_q     <= '0;
      hist_q    <= '0;
      ready_q   <= 1'b1;
      dout_q    <= 1'b0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      hist_q <= hist_d;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (load) begin
            word_q    <= pat_data;
            rep_q     <= repeat_cnt;
            gap_cfg_q <= gap;
            idx_q     <= IDX_MSB;
            dout_q    <= pat_data[WIDTH-1];
            valid_q   <= 1'b1;
            ready_q   <= 1'b0;
            state_q   <= SHIFT;
          end
        end
        SHIFT: begin
          if (idx_q != '0) begin
            idx_q  <= idx_d;
            dout_q <= word_q[idx_d];
          end else if (rep_q != 8'd0) begin
            rep_q <= rep_q - 8'd1;
            if (gap_cfg_q != 4'd0) begin
              gap_cnt_q <= gap_cfg_q;
              dout_q    <= 1'b0;
              valid_q   <= 1'b0;
              state_q   <= GAP;
            end else begin
              idx_q  <= IDX_MSB;
              dout_q <= word_q[WIDTH-1];
            end
          end else begin
            dout_q  <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        GAP: begin
          if (gap_cnt_q == 4'd1) begin
            idx_q   <= IDX_MSB;
            dout_q  <= word_q[WIDTH-1];
            valid_q <= 1'b1;
            state_q <= SHIFT;
          end else begin
            gap_cnt_q <= gap_cnt_q - 4'd1;
          end
        end
        DONE: begin
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ready      = ready_q;
  assign dout       = dout_q;
  assign dout_valid = valid_q;
  assign done       = done_q;
  // Mealy: the bit on dout this cycle completes the window
  assign match_exp  = (window == TARGET);

endmodule
